// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// Module : instr_fetch_unit_pkg
// Brief  : Fetch FSM state encodings, R-type field positions and PC step.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_VALID = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_t;

   localparam int OPC_HI   = 31;
   localparam int OPC_LO   = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int SHAMT_HI = 10;
   localparam int SHAMT_LO = 6;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;

   localparam int PC_INC   = 4;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Brief  : PC/IR fetch stage: req/ack instruction memory in, valid/ready out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [5:0]        opcode,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [5:0]        funct,
   output logic [ADDR_W-1:0] pc_out
);

   fetch_state_t      r_state;
   fetch_state_t      w_state_next;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_next;
   logic [31:0]       r_ir;
   logic [ADDR_W-1:0] r_pc_out;
   logic              w_ir_load;
   logic [ADDR_W-1:0] w_redirect_aligned;
   logic              w_in_handshake;

   assign w_redirect_aligned = redirect_pc & ~ADDR_W'(3);
   assign w_in_handshake     = (r_state == ST_REQ) || (r_state == ST_DRAIN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_pc     <= RESET_PC;
         r_addr   <= RESET_PC;
         r_ir     <= '0;
         r_pc_out <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_addr  <= w_addr_next;
         if (w_ir_load) begin
            r_ir     <= imem_rdata;
            r_pc_out <= r_addr;
         end
      end
   end

   // r_addr is the address presented on the bus; it only moves when a new
   // request starts, so a redirect mid-handshake leaves it pinned.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_addr_next  = r_addr;
      w_ir_load    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_state_next = ST_REQ;
            w_addr_next  = r_pc;
         end
         ST_REQ: begin
            if (imem_ack) begin
               w_ir_load    = 1'b1;
               w_pc_next    = r_addr + ADDR_W'(PC_INC);
               w_state_next = ST_VALID;
            end
         end
         ST_VALID: begin
            if (instr_ready) begin
               w_state_next = ST_REQ;
               w_addr_next  = r_pc;
            end
         end
         ST_DRAIN: begin
            if (imem_ack) begin
               w_state_next = ST_REQ;
               w_addr_next  = r_pc;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      // An ack arriving with the redirect closes the old handshake, so the
      // new target can be requested straight away even from DRAIN.
      if (redirect) begin
         w_pc_next = w_redirect_aligned;
         w_ir_load = 1'b0;
         if (w_in_handshake && !imem_ack) begin
            w_state_next = ST_DRAIN;
            w_addr_next  = r_addr;
         end else begin
            w_state_next = ST_REQ;
            w_addr_next  = w_redirect_aligned;
         end
      end
   end

   assign imem_req    = w_in_handshake;
   assign imem_addr   = r_addr;
   assign instr_valid = (r_state == ST_VALID);
   assign pc_out      = r_pc_out;

   assign opcode = r_ir[OPC_HI:OPC_LO];
   assign rs     = r_ir[RS_HI:RS_LO];
   assign rt     = r_ir[RT_HI:RT_LO];
   assign rd     = r_ir[RD_HI:RD_LO];
   assign shamt  = r_ir[SHAMT_HI:SHAMT_LO];
   assign funct  = r_ir[FUNCT_HI:FUNCT_LO];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Directed and randomized checking of instr_fetch_unit vs a
//          transaction-level model (outstanding request / held instruction).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [31:0] pc_out;

   int n_checks = 0;
   int n_fail   = 0;

   instr_fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .shamt       (shamt),
      .funct       (funct),
      .pc_out      (pc_out)
   );

   always #5 clk = ~clk;

   // Model: a fetch is either waiting to start, outstanding on the bus
   // (possibly marked to be thrown away), or finished and held for hand-off.
   bit          m_start_pending;
   bit          m_outstanding;
   bit          m_discard;
   bit          m_held;
   logic [31:0] m_pc;
   logic [31:0] m_bus_addr;
   logic [31:0] m_word;
   logic [31:0] m_word_pc;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_edge(bit rn, bit ack, logic [31:0] rdata,
                                      bit redir, logic [31:0] rpc, bit rdy);
      logic [31:0] target;
      target = {rpc[31:2], 2'b00};
      if (!rn) begin
         m_start_pending = 1;
         m_outstanding   = 0;
         m_discard       = 0;
         m_held          = 0;
         m_pc            = 32'h0;
         m_word          = '0;
         m_word_pc       = '0;
      end else if (redir) begin
         m_pc            = target;
         m_held          = 0;
         m_start_pending = 0;
         if (m_outstanding && !ack) begin
            m_discard = 1;
         end else begin
            m_outstanding = 1;
            m_discard     = 0;
            m_bus_addr    = target;
         end
      end else if (m_start_pending) begin
         m_start_pending = 0;
         m_outstanding   = 1;
         m_discard       = 0;
         m_bus_addr      = m_pc;
      end else if (m_outstanding && ack) begin
         if (m_discard) begin
            m_discard  = 0;
            m_bus_addr = m_pc;
         end else begin
            m_word        = rdata;
            m_word_pc     = m_bus_addr;
            m_pc          = m_bus_addr + 32'd4;
            m_outstanding = 0;
            m_held        = 1;
         end
      end else if (m_held && rdy) begin
         m_held        = 0;
         m_outstanding = 1;
         m_bus_addr    = m_pc;
      end
   endfunction

   function automatic void compare_all();
      check("imem_req", {31'b0, imem_req}, {31'b0, m_outstanding});
      if (m_outstanding) check("imem_addr", imem_addr, m_bus_addr);
      check("instr_valid", {31'b0, instr_valid}, {31'b0, m_held});
      if (m_held) begin
         check("opcode", {26'b0, opcode}, {26'b0, m_word[31:26]});
         check("rs",     {27'b0, rs},     {27'b0, m_word[25:21]});
         check("rt",     {27'b0, rt},     {27'b0, m_word[20:16]});
         check("rd",     {27'b0, rd},     {27'b0, m_word[15:11]});
         check("shamt",  {27'b0, shamt},  {27'b0, m_word[10:6]});
         check("funct",  {26'b0, funct},  {26'b0, m_word[5:0]});
         check("pc_out", pc_out, m_word_pc);
      end
   endfunction

   // Called at a negedge: drive, take the edge, update model, compare.
   task automatic step(input bit rn, input bit ack, input logic [31:0] rdata,
                       input bit redir, input logic [31:0] rpc, input bit rdy);
      rst_n       = rn;
      imem_ack    = ack;
      imem_rdata  = rdata;
      redirect    = redir;
      redirect_pc = rpc;
      instr_ready = rdy;
      @(posedge clk);
      model_edge(rn, ack, rdata, redir, rpc, rdy);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      m_start_pending = 1;
      m_outstanding   = 0;
      m_discard       = 0;
      m_held          = 0;
      m_pc            = '0;
      m_bus_addr      = '0;
      m_word          = '0;
      m_word_pc       = '0;
      @(negedge clk);

      // Reset state
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);

      // First fetch: add $8,$9,$10
      step(1, 0, 0, 0, 0, 1);
      check("first_req", {31'b0, imem_req}, 32'd1);
      check("first_addr", imem_addr, 32'h0);
      step(1, 1, 32'h012A4020, 0, 0, 0);
      check("first_valid", {31'b0, instr_valid}, 32'd1);
      check("first_opc", {26'b0, opcode}, 32'd0);
      check("first_rs", {27'b0, rs}, 32'd9);
      check("first_rt", {27'b0, rt}, 32'd10);
      check("first_rd", {27'b0, rd}, 32'd8);
      check("first_funct", {26'b0, funct}, 32'h20);
      check("first_pcout", pc_out, 32'h0);
      step(1, 0, 0, 0, 0, 1);
      check("second_addr", imem_addr, 32'h4);

      // Stall with ready low
      step(1, 1, 32'h8D0A_FFF0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 32'hDEAD_BEEF, 0, 0, 0);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_pcout", pc_out, 32'h4);
      check("stall_opc", {26'b0, opcode}, 32'h23);
      step(1, 0, 0, 0, 0, 1);
      check("third_addr", imem_addr, 32'h8);

      // Redirect mid-handshake, ack arrives 3 cycles late
      step(1, 0, 0, 1, 32'h43, 0);
      check("drain_req", {31'b0, imem_req}, 32'd1);
      check("drain_addr", imem_addr, 32'h8);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 1, 32'hFFFF_FFFF, 0, 0, 1);
      check("drain_done_valid", {31'b0, instr_valid}, 32'd0);
      check("drain_done_addr", imem_addr, 32'h40);

      // Redirect coincident with ack
      step(1, 1, 32'h1234_5678, 1, 32'h100, 1);
      check("redir_ack_valid", {31'b0, instr_valid}, 32'd0);
      check("redir_ack_addr", imem_addr, 32'h100);

      // Redirect while valid with ready high
      step(1, 1, 32'h0000_0001, 0, 0, 0);
      step(1, 0, 0, 1, 32'h200, 1);
      check("redir_valid_valid", {31'b0, instr_valid}, 32'd0);
      check("redir_valid_addr", imem_addr, 32'h200);

      // PC wrap
      step(1, 1, 32'h0, 1, 32'hFFFF_FFFE, 1);
      check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
      step(1, 1, 32'hAC00_0000, 0, 0, 0);
      check("wrap_pcout", pc_out, 32'hFFFF_FFFC);
      step(1, 0, 0, 0, 0, 1);
      check("wrap_addr", imem_addr, 32'h0);

      // Reset mid-REQ
      step(0, 0, 0, 0, 0, 1);
      check("midrst_req", {31'b0, imem_req}, 32'd0);
      step(1, 0, 0, 0, 0, 1);
      check("midrst_addr", imem_addr, 32'h0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bit          rn;
         bit          ack;
         bit          redir;
         bit          rdy;
         logic [31:0] rpc;
         rn    = ($urandom_range(0, 249) != 0);
         ack   = m_outstanding && ($urandom_range(0, 2) == 0);
         redir = ($urandom_range(0, 15) == 0);
         rdy   = ($urandom_range(0, 2) != 0);
         rpc   = $urandom;
         step(rn, ack, $urandom, redir, rpc, rdy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
